// File: rtl/arb_perfis_if.sv
// Request/grant bundle between the two user profiles and the arbitration stage.
interface arb_perfis_if #(
    parameter int FW = 3
);
    logic          REQ_A;
    logic [FW-1:0] FUN_A;
    logic          REQ_B;
    logic [FW-1:0] FUN_B;
    logic          PRIO;
    logic          FUN_IG;
    logic          GNT_A;
    logic          GNT_B;
    logic [FW-1:0] FUN_ATV;
    logic          BUSY;
    logic          DONE;

    // Requester side drives the requests and observes the arbitration result.
    modport master (
        output REQ_A, FUN_A, REQ_B, FUN_B,
        input  PRIO, FUN_IG, GNT_A, GNT_B, FUN_ATV, BUSY, DONE
    );

    // Arbiter side.
    modport slave (
        input  REQ_A, FUN_A, REQ_B, FUN_B,
        output PRIO, FUN_IG, GNT_A, GNT_B, FUN_ATV, BUSY, DONE
    );
endinterface

// File: rtl/arb_perfis.sv
// Two-profile arbiter: samples both requests while idle, flags equal-code
// conflicts, rotates priority on each conflict and holds every grant active
// for T_ATIV cycles, chaining A then B when both ask for different codes.
module arb_perfis #(
    parameter int FW     = 3,
    parameter int T_ATIV = 8
) (
    input  logic         CLK,
    input  logic         RST,
    arb_perfis_if.slave  bus
);
    typedef enum logic [1:0] {IDLE = 2'd0, SERVE_A = 2'd1, SERVE_B = 2'd2} state_t;

    localparam logic [7:0] LAST = 8'(T_ATIV - 1);

    state_t        state_q, state_d;
    logic [7:0]    cnt_q, cnt_d;
    logic          pend_b_q, pend_b_d;
    logic [FW-1:0] code_a_q, code_a_d;
    logic [FW-1:0] code_b_q, code_b_d;
    logic          prio_q, prio_d;
    logic          fun_ig_q, fun_ig_d;

    logic          last;
    logic          ig;
    logic          en_a;
    logic          en_b;

    assign last = (cnt_q == LAST);

    // Equal-code conflict and grant enables, evaluated on the pre-edge priority.
    assign ig   = bus.REQ_A & bus.REQ_B & (bus.FUN_A == bus.FUN_B);
    assign en_a = bus.REQ_A & (prio_q | ~ig);
    assign en_b = bus.REQ_B & (~prio_q | ~ig);

    // State register: reset aborts any service immediately, no DONE.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            pend_b_q <= 1'b0;
            code_a_q <= '0;
            code_b_q <= '0;
            prio_q   <= 1'b1;
            fun_ig_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            pend_b_q <= pend_b_d;
            code_a_q <= code_a_d;
            code_b_q <= code_b_d;
            prio_q   <= prio_d;
            fun_ig_q <= fun_ig_d;
        end
    end

    // Next-state: sampling only happens in IDLE; requests during service are dropped.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        pend_b_d = pend_b_q;
        code_a_d = code_a_q;
        code_b_d = code_b_q;
        prio_d   = prio_q;
        fun_ig_d = fun_ig_q;
        case (state_q)
            IDLE: begin
                cnt_d    = '0;
                fun_ig_d = ig;
                if (ig) prio_d = ~prio_q;
                if (en_a) begin
                    state_d  = SERVE_A;
                    code_a_d = bus.FUN_A;
                    pend_b_d = en_b;
                    if (en_b) code_b_d = bus.FUN_B;
                end else if (en_b) begin
                    state_d  = SERVE_B;
                    code_b_d = bus.FUN_B;
                end
            end
            SERVE_A: begin
                cnt_d = cnt_q + 8'd1;
                if (last) begin
                    cnt_d = '0;
                    if (pend_b_q) begin
                        // Chain straight into B's service without an idle gap.
                        state_d  = SERVE_B;
                        pend_b_d = 1'b0;
                    end else begin
                        state_d  = IDLE;
                        fun_ig_d = 1'b0;
                    end
                end
            end
            SERVE_B: begin
                cnt_d = cnt_q + 8'd1;
                if (last) begin
                    cnt_d    = '0;
                    state_d  = IDLE;
                    fun_ig_d = 1'b0;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Outputs decode registered state only, so inputs never reach outputs combinationally.
    always_comb begin
        bus.GNT_A   = (state_q == SERVE_A);
        bus.GNT_B   = (state_q == SERVE_B);
        bus.BUSY    = (state_q == SERVE_A) || (state_q == SERVE_B);
        bus.DONE    = bus.BUSY & last;
        bus.PRIO    = prio_q;
        bus.FUN_IG  = fun_ig_q;
        bus.FUN_ATV = '0;
        if (state_q == SERVE_A) bus.FUN_ATV = code_a_q;
        if (state_q == SERVE_B) bus.FUN_ATV = code_b_q;
    end
endmodule
